// File: rtl/bgr_trim_sar_if.sv
// ---------------------------------------------------------------------------
// bgr_trim_sar_if
// Bundle between the digital I/O side and the bandgap trim controller.
//   start       : single-cycle calibration request         (master -> slave)
//   cmp_in      : async comparator, 1 = VREF above target   (master -> slave)
//   manual_en   : manual trim override                      (master -> slave)
//   manual_code : manual trim value                         (master -> slave)
//   trim_out    : registered trim code to the BGR DAC       (slave -> master)
//   busy        : calibration in progress                   (slave -> master)
//   done        : calibration finished, held                (slave -> master)
//   cal_ok      : result not saturated, valid with done     (slave -> master)
// ---------------------------------------------------------------------------
interface bgr_trim_sar_if #(
    parameter int TRIM_W = 6
);
    logic              start;
    logic              cmp_in;
    logic              manual_en;
    logic [TRIM_W-1:0] manual_code;
    logic [TRIM_W-1:0] trim_out;
    logic              busy;
    logic              done;
    logic              cal_ok;

    modport master (
        output start, cmp_in, manual_en, manual_code,
        input  trim_out, busy, done, cal_ok
    );

    modport slave (
        input  start, cmp_in, manual_en, manual_code,
        output trim_out, busy, done, cal_ok
    );
endinterface

// File: rtl/bgr_trim_sar.sv
// ---------------------------------------------------------------------------
// bgr_trim_sar
// Successive-approximation trim controller for the bandgap reference.
// Searches MSB first for the trim code that centres VREF, using a
// synchronised, majority-voted comparator reading per bit. A manual override
// forces the trim code directly and aborts any calibration.
// Ports:
//   clk : system clock
//   rst : synchronous reset, active-high
//   bus : bgr_trim_sar_if.slave (start, cmp_in, manual_en, manual_code in;
//         trim_out, busy, done, cal_ok out, all outputs registered)
// ---------------------------------------------------------------------------
module bgr_trim_sar #(
    parameter int TRIM_W     = 6,
    parameter int SETTLE_CYC = 16
) (
    input  logic         clk,
    input  logic         rst,
    bgr_trim_sar_if.slave bus
);
    localparam int BIT_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [TRIM_W-1:0] MID_CODE = {1'b1, {(TRIM_W-1){1'b0}}};
    localparam logic [TRIM_W-1:0] ALL_ONES = {TRIM_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [TRIM_W-1:0] trim_q;
    logic [BIT_W-1:0]  bit_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        smp_cnt_q;
    logic [2:0]        smp_q;
    logic              cmp_s1_q;
    logic              cmp_s2_q;
    logic              busy_q;
    logic              done_q;
    logic              cal_ok_q;

    logic [TRIM_W-1:0] dec_code;
    logic [TRIM_W-1:0] nxt_trial;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    // Two-flop synchroniser for the asynchronous comparator output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_s1_q <= 1'b0;
            cmp_s2_q <= 1'b0;
        end else begin
            cmp_s1_q <= bus.cmp_in;
            cmp_s2_q <= cmp_s1_q;
        end
    end

    // Resolve the bit under test (VREF too high -> drop the bit), then
    // prepare the next lower trial bit.
    always_comb begin
        dec_code = trim_q;
        if (maj3(smp_q)) begin
            dec_code[bit_q] = 1'b0;
        end
        nxt_trial = dec_code;
        if (bit_q != '0) begin
            nxt_trial[bit_q - BIT_W'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            trim_q    <= MID_CODE;
            bit_q     <= '0;
            cnt_q     <= '0;
            smp_cnt_q <= '0;
            smp_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cal_ok_q  <= 1'b0;
        end else if (bus.manual_en) begin
            // Override beats everything, including a same-cycle start.
            state_q  <= S_IDLE;
            trim_q   <= bus.manual_code;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cal_ok_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_q  <= S_SETTLE;
                        trim_q   <= MID_CODE;
                        bit_q    <= BIT_W'(TRIM_W - 1);
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        cal_ok_q <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                        state_q   <= S_SAMPLE;
                        cnt_q     <= '0;
                        smp_cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    smp_q     <= {smp_q[1:0], cmp_s2_q};
                    smp_cnt_q <= smp_cnt_q + 2'd1;
                    if (smp_cnt_q == 2'd2) begin
                        state_q <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    if (bit_q != '0) begin
                        trim_q  <= nxt_trial;
                        bit_q   <= bit_q - BIT_W'(1);
                        cnt_q   <= '0;
                        state_q <= S_SETTLE;
                    end else begin
                        trim_q   <= dec_code;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        cal_ok_q <= (dec_code != '0) && (dec_code != ALL_ONES);
                        state_q  <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.trim_out = trim_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.cal_ok   = cal_ok_q;
endmodule

// File: tb/tb_bgr_trim_sar.sv
// ---------------------------------------------------------------------------
// tb_bgr_trim_sar
// Directed bench for the bandgap trim SAR controller. A behavioural
// comparator model (cmp = trim_out > target, or forced 0/1, optionally
// inverted for one cycle) closes the loop around the DUT.
// ---------------------------------------------------------------------------
module tb_bgr_trim_sar;
    localparam int TRIM_W     = 6;
    localparam int SETTLE_CYC = 16;
    localparam int PER_BIT    = SETTLE_CYC + 4;
    localparam int CAL_CYC    = TRIM_W * PER_BIT;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    int   target;
    logic force1;
    logic force0;
    logic inv;

    bgr_trim_sar_if #(.TRIM_W(TRIM_W)) bus ();

    bgr_trim_sar #(
        .TRIM_W    (TRIM_W),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    assign bus.cmp_in = (force1 ? 1'b1 :
                         force0 ? 1'b0 :
                         (int'(bus.trim_out) > target)) ^ inv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   tgt;
        logic f1;
        logic f0;
        int   exp_trim;
        logic exp_ok;
    } vec_t;

    vec_t vecs[5];
    int   seq37[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_model(input int tgt, input logic f1, input logic f0);
        target = tgt;
        force1 = f1;
        force0 = f0;
        inv    = 1'b0;
    endtask

    // Pulse start and follow one full calibration cycle by cycle.
    // inject_at: cycle at which cmp_in is inverted for one clock (-1 = none)
    // restart_at: cycle at which a spurious start pulse is issued (-1 = none)
    task automatic run_cal(input string tag, input int exp_trim, input logic exp_ok,
                           input int inject_at, input int restart_at,
                           input logic chk_seq);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check({tag, "_busy_start"}, int'(bus.busy), 1);
        check({tag, "_done_start"}, int'(bus.done), 0);
        if (chk_seq) check({tag, "_trim_0"}, int'(bus.trim_out), seq37[0]);
        for (int i = 1; i <= CAL_CYC; i++) begin
            if (i - 1 == inject_at)  inv = 1'b1;
            if (i - 1 == inject_at + 1) inv = 1'b0;
            if (i - 1 == restart_at) bus.start = 1'b1;
            if (i - 1 == restart_at + 1) bus.start = 1'b0;
            step();
            if (chk_seq && (i % PER_BIT == 0) && (i < CAL_CYC))
                check($sformatf("%s_trim_%0d", tag, i), int'(bus.trim_out),
                      seq37[i / PER_BIT]);
            if (i == CAL_CYC - 1) check({tag, "_done_early"}, int'(bus.done), 0);
        end
        bus.start = 1'b0;
        inv       = 1'b0;
        check({tag, "_done"},   int'(bus.done),     1);
        check({tag, "_busy"},   int'(bus.busy),     0);
        check({tag, "_trim"},   int'(bus.trim_out), exp_trim);
        check({tag, "_cal_ok"}, int'(bus.cal_ok),   int'(exp_ok));
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.manual_en   = 1'b0;
        bus.manual_code = '0;
        set_model(37, 1'b0, 1'b0);

        seq37[0] = 32; seq37[1] = 48; seq37[2] = 40;
        seq37[3] = 36; seq37[4] = 38; seq37[5] = 37;

        vecs[0] = '{tgt: 37, f1: 1'b0, f0: 1'b0, exp_trim: 37, exp_ok: 1'b1};
        vecs[1] = '{tgt: 0,  f1: 1'b1, f0: 1'b0, exp_trim: 0,  exp_ok: 1'b0};
        vecs[2] = '{tgt: 63, f1: 1'b0, f0: 1'b1, exp_trim: 63, exp_ok: 1'b0};
        vecs[3] = '{tgt: 10, f1: 1'b0, f0: 1'b0, exp_trim: 10, exp_ok: 1'b1};
        vecs[4] = '{tgt: 62, f1: 1'b0, f0: 1'b0, exp_trim: 62, exp_ok: 1'b1};

        repeat (3) step();
        check("rst_trim",   int'(bus.trim_out), 32);
        check("rst_busy",   int'(bus.busy),     0);
        check("rst_done",   int'(bus.done),     0);
        check("rst_cal_ok", int'(bus.cal_ok),   0);
        rst = 1'b0;
        step();

        // Table-driven calibrations; each one starts from the previous DONE.
        for (int v = 0; v < 5; v++) begin
            set_model(vecs[v].tgt, vecs[v].f1, vecs[v].f0);
            run_cal($sformatf("vec%0d", v), vecs[v].exp_trim, vecs[v].exp_ok,
                    -1, -1, (v == 0));
        end

        // Result and done held in DONE.
        repeat (10) step();
        check("hold_done", int'(bus.done),     1);
        check("hold_trim", int'(bus.trim_out), 62);

        // One inverted comparator sample inside the MSB sample window.
        set_model(37, 1'b0, 1'b0);
        run_cal("glitch", 37, 1'b1, SETTLE_CYC - 1, -1, 1'b1);

        // Spurious start at cycle 50 is ignored.
        run_cal("restart", 37, 1'b1, -1, 50, 1'b1);

        // Manual override mid-calibration.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (30) step();
        bus.manual_en   = 1'b1;
        bus.manual_code = 6'd13;
        step();
        check("man_trim",   int'(bus.trim_out), 13);
        check("man_busy",   int'(bus.busy),     0);
        check("man_done",   int'(bus.done),     0);
        check("man_cal_ok", int'(bus.cal_ok),   0);
        bus.manual_code = 6'd21;
        step();
        check("man_track", int'(bus.trim_out), 21);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("man_start_busy", int'(bus.busy),     0);
        check("man_start_trim", int'(bus.trim_out), 21);
        bus.manual_code = 6'd13;
        step();
        bus.manual_en = 1'b0;
        step();
        bus.manual_code = 6'd5;
        repeat (5) step();
        check("rel_trim", int'(bus.trim_out), 13);
        check("rel_busy", int'(bus.busy),     0);
        check("rel_done", int'(bus.done),     0);

        run_cal("post_man", 37, 1'b1, -1, -1, 1'b0);

        // Reset at cycle 70 of a calibration.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (70) step();
        rst = 1'b1;
        step();
        check("mid_rst_trim",   int'(bus.trim_out), 32);
        check("mid_rst_busy",   int'(bus.busy),     0);
        check("mid_rst_done",   int'(bus.done),     0);
        check("mid_rst_cal_ok", int'(bus.cal_ok),   0);
        rst = 1'b0;
        step();
        set_model(10, 1'b0, 1'b0);
        run_cal("post_rst", 10, 1'b1, -1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
